// File: rtl/radar_stats_pkg.sv
// Shared types and helpers for the radar statistics calibrator.
//   state_t        : lock state machine encoding (also exposed on dbg_state)
//   DEF_DATA_WIDTH : default width of the statistic counters
//   sat_inc        : increment that sticks at a caller-supplied maximum
//   abs_diff       : |a - b| computed as larger minus smaller, never wraps
// The helpers work on FN_W bits; callers zero-extend narrower counters
// and truncate the result back, so any DATA_WIDTH up to FN_W is supported.
package radar_stats_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        CHECK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int FN_W           = 64;

    function automatic logic [FN_W-1:0] sat_inc(input logic [FN_W-1:0] v,
                                                input logic [FN_W-1:0] max_v);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

    function automatic logic [FN_W-1:0] abs_diff(input logic [FN_W-1:0] a,
                                                 input logic [FN_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an input already synchronised to clk.
//   clk  : clock
//   rst  : synchronous active-high reset, clears the previous-value flop
//   din  : level input
//   rise : combinational, high in the first cycle din is seen high
// A level held high produces a single rise.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev_d;
    logic prev_q;

    always_comb begin
        prev_d = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/radar_stats_calibrator.sv
// Revolution statistics and lock controller for the radar datapath.
// Measures every antenna revolution (ARP rise to ARP rise): period in
// US_CLK cycles, ACP rises and TRIG rises. CALIBRATED is asserted after
// CAL_REVS consecutive revolutions agree with a reference revolution.
//   US_CLK     : 1 MHz clock
//   RST        : synchronous active-high reset
//   ARP/ACP/TRIG : synchronised pulse inputs
//   ARP_US, ACP_CNT, TRIG_CNT : statistics of the last published revolution
//   CALIBRATED : high while LOCKED
//   STAT_VALID : one-cycle pulse when the statistics outputs change
//   ARP_LOST   : sticky ARP timeout flag, cleared by reset or the next lock
//   dbg_state  : current lock state (radar_stats_pkg::state_t encoding)
// STAT_VALID has no ready: the consumer must take ARP_US/ACP_CNT/TRIG_CNT in
// the cycle STAT_VALID is high; the values then hold until the next pulse.
module radar_stats_calibrator
    import radar_stats_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CAL_REVS    = 4,
    parameter int US_TOL      = 2,
    parameter int ARP_TIMEOUT = 8_000_000
) (
    input  logic                  US_CLK,
    input  logic                  RST,
    input  logic                  ARP,
    input  logic                  ACP,
    input  logic                  TRIG,
    output logic [DATA_WIDTH-1:0] ARP_US,
    output logic [DATA_WIDTH-1:0] ACP_CNT,
    output logic [DATA_WIDTH-1:0] TRIG_CNT,
    output logic                  CALIBRATED,
    output logic                  STAT_VALID,
    output logic                  ARP_LOST,
    output logic [1:0]            dbg_state
);

    localparam logic [DATA_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_CNT = DATA_WIDTH'(ARP_TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] TOL         = DATA_WIDTH'(US_TOL);
    localparam logic [3:0]            REVS        = 4'(CAL_REVS);

    function automatic logic [DATA_WIDTH-1:0] inc(input logic [DATA_WIDTH-1:0] v);
        return DATA_WIDTH'(sat_inc(FN_W'(v), FN_W'(CNT_MAX)));
    endfunction

    logic arp_rise, acp_rise, trig_rise;

    rise_detect u_arp  (.clk(US_CLK), .rst(RST), .din(ARP),  .rise(arp_rise));
    rise_detect u_acp  (.clk(US_CLK), .rst(RST), .din(ACP),  .rise(acp_rise));
    rise_detect u_trig (.clk(US_CLK), .rst(RST), .din(TRIG), .rise(trig_rise));

    state_t                state_d, state_q;
    logic [DATA_WIDTH-1:0] us_cnt_d, us_cnt_q;
    logic [DATA_WIDTH-1:0] acp_run_d, acp_run_q;
    logic [DATA_WIDTH-1:0] trig_run_d, trig_run_q;
    logic [DATA_WIDTH-1:0] ref_us_d, ref_us_q;
    logic [DATA_WIDTH-1:0] ref_acp_d, ref_acp_q;
    logic [3:0]            match_cnt_d, match_cnt_q;
    logic [DATA_WIDTH-1:0] arp_us_d, arp_us_q;
    logic [DATA_WIDTH-1:0] acp_cnt_d, acp_cnt_q;
    logic [DATA_WIDTH-1:0] trig_cnt_d, trig_cnt_q;
    logic                  calibrated_d, calibrated_q;
    logic                  stat_valid_d, stat_valid_q;
    logic                  arp_lost_d, arp_lost_q;

    logic [DATA_WIDTH-1:0] rev_us;
    logic                  rev_match;
    logic                  timeout;
    logic                  publish, take_ref, lock;

    always_comb begin
        // Period of the revolution closing on this ARP rise.
        rev_us    = inc(us_cnt_q);
        // A saturated period is meaningless, so it always forces a new reference.
        rev_match = (us_cnt_q != CNT_MAX)
                 && (DATA_WIDTH'(abs_diff(FN_W'(rev_us), FN_W'(ref_us_q))) <= TOL)
                 && (acp_run_q == ref_acp_q);
        // A real ARP rise on the timeout cycle takes priority.
        timeout   = (state_q != IDLE) && !arp_rise && (us_cnt_q == TIMEOUT_CNT);

        state_d      = state_q;
        us_cnt_d     = us_cnt_q;
        acp_run_d    = acp_run_q;
        trig_run_d   = trig_run_q;
        ref_us_d     = ref_us_q;
        ref_acp_d    = ref_acp_q;
        match_cnt_d  = match_cnt_q;
        arp_us_d     = arp_us_q;
        acp_cnt_d    = acp_cnt_q;
        trig_cnt_d   = trig_cnt_q;
        calibrated_d = calibrated_q;
        stat_valid_d = 1'b0;
        arp_lost_d   = arp_lost_q;
        publish      = 1'b0;
        take_ref     = 1'b0;
        lock         = 1'b0;

        // Running counters; ACP/TRIG rises coincident with ARP open the new revolution.
        if (arp_rise) begin
            us_cnt_d   = '0;
            acp_run_d  = DATA_WIDTH'(acp_rise);
            trig_run_d = DATA_WIDTH'(trig_rise);
        end else begin
            us_cnt_d = inc(us_cnt_q);
            if (acp_rise) begin
                acp_run_d = inc(acp_run_q);
            end
            if (trig_rise) begin
                trig_run_d = inc(trig_run_q);
            end
        end

        if (arp_rise) begin
            unique case (state_q)
                IDLE: begin
                    // Partial revolution before the first ARP is discarded.
                    state_d = MEASURE;
                end
                MEASURE: begin
                    publish  = 1'b1;
                    take_ref = 1'b1;
                    if (REVS == 4'd1) begin
                        lock = 1'b1;
                    end else begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    publish = 1'b1;
                    if (rev_match) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_q + 4'd1 >= REVS) begin
                            lock = 1'b1;
                        end
                    end else begin
                        take_ref = 1'b1;
                    end
                end
                LOCKED: begin
                    publish = 1'b1;
                    if (!rev_match) begin
                        take_ref     = 1'b1;
                        state_d      = CHECK;
                        calibrated_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d      = IDLE;
            calibrated_d = 1'b0;
            arp_lost_d   = 1'b1;
        end

        if (publish) begin
            arp_us_d     = rev_us;
            acp_cnt_d    = acp_run_q;
            trig_cnt_d   = trig_run_q;
            stat_valid_d = 1'b1;
        end
        if (take_ref) begin
            ref_us_d    = rev_us;
            ref_acp_d   = acp_run_q;
            match_cnt_d = 4'd1;
        end
        if (lock) begin
            state_d      = LOCKED;
            calibrated_d = 1'b1;
            arp_lost_d   = 1'b0;
        end
    end

    always_ff @(posedge US_CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            us_cnt_q     <= '0;
            acp_run_q    <= '0;
            trig_run_q   <= '0;
            ref_us_q     <= '0;
            ref_acp_q    <= '0;
            match_cnt_q  <= '0;
            arp_us_q     <= '0;
            acp_cnt_q    <= '0;
            trig_cnt_q   <= '0;
            calibrated_q <= 1'b0;
            stat_valid_q <= 1'b0;
            arp_lost_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            us_cnt_q     <= us_cnt_d;
            acp_run_q    <= acp_run_d;
            trig_run_q   <= trig_run_d;
            ref_us_q     <= ref_us_d;
            ref_acp_q    <= ref_acp_d;
            match_cnt_q  <= match_cnt_d;
            arp_us_q     <= arp_us_d;
            acp_cnt_q    <= acp_cnt_d;
            trig_cnt_q   <= trig_cnt_d;
            calibrated_q <= calibrated_d;
            stat_valid_q <= stat_valid_d;
            arp_lost_q   <= arp_lost_d;
        end
    end

    assign ARP_US     = arp_us_q;
    assign ACP_CNT    = acp_cnt_q;
    assign TRIG_CNT   = trig_cnt_q;
    assign CALIBRATED = calibrated_q;
    assign STAT_VALID = stat_valid_q;
    assign ARP_LOST   = arp_lost_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_radar_stats_calibrator.sv
// Directed bench for radar_stats_calibrator. Each table record describes one
// revolution (period, ACP/TRIG counts, ARP hold length) and the outputs
// expected right after the ARP rise that closes it. Timeout and mid-CHECK
// reset are hand-written sequences between table sections.
module tb_radar_stats_calibrator;

    localparam int DW = 32;
    localparam int ST_IDLE    = 0;
    localparam int ST_MEASURE = 1;
    localparam int ST_CHECK   = 2;
    localparam int ST_LOCKED  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          arp, acp, trig;
    logic [DW-1:0] arp_us, acp_cnt, trig_cnt;
    logic          calibrated, stat_valid, arp_lost;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   period;
        int   acp_n;
        int   trig_n;
        int   arp_hi;
        int   exp_us;
        int   exp_acp;
        int   exp_trig;
        logic exp_cal;
        logic exp_lost;
        int   exp_state;
    } rev_t;

    rev_t tbl[$];

    always #5 clk = ~clk;

    radar_stats_calibrator #(
        .DATA_WIDTH (DW),
        .CAL_REVS   (4),
        .US_TOL     (2),
        .ARP_TIMEOUT(5000)
    ) dut (
        .US_CLK    (clk),
        .RST       (rst),
        .ARP       (arp),
        .ACP       (acp),
        .TRIG      (trig),
        .ARP_US    (arp_us),
        .ACP_CNT   (acp_cnt),
        .TRIG_CNT  (trig_cnt),
        .CALIBRATED(calibrated),
        .STAT_VALID(stat_valid),
        .ARP_LOST  (arp_lost),
        .dbg_state (dbg_state)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, return 1 time unit later.
    task automatic apply(input logic a, input logic c, input logic t);
        arp  = a;
        acp  = c;
        trig = t;
        @(posedge clk);
        #1;
    endtask

    task automatic arp_edge();
        apply(1'b1, 1'b1, 1'b1);
    endtask

    // Cycles 1..period-1 of a revolution whose cycle 0 was an arp_edge.
    task automatic body(input int p, input int an, input int tn, input int hi,
                        output int vcnt);
        vcnt = 0;
        for (int k = 1; k < p; k++) begin
            apply(k < hi, (k % 10 == 0) && (k / 10 < an), (k % 2 == 0) && (k / 2 < tn));
            if (stat_valid) vcnt++;
        end
    endtask

    task automatic run_rev(input int idx, input rev_t r);
        int vc;
        body(r.period, r.acp_n, r.trig_n, r.arp_hi, vc);
        check($sformatf("rev%0d stray_valid", idx), vc, 0);
        arp_edge();
        check($sformatf("rev%0d stat_valid", idx), stat_valid, 1);
        check($sformatf("rev%0d arp_us", idx), arp_us, r.exp_us);
        check($sformatf("rev%0d acp_cnt", idx), acp_cnt, r.exp_acp);
        check($sformatf("rev%0d trig_cnt", idx), trig_cnt, r.exp_trig);
        check($sformatf("rev%0d calibrated", idx), calibrated, r.exp_cal);
        check($sformatf("rev%0d arp_lost", idx), arp_lost, r.exp_lost);
        check($sformatf("rev%0d state", idx), dbg_state, r.exp_state);
    endtask

    function automatic rev_t mk(int p, int a, int t, int h, int us, int ac, int tr,
                                logic cal, logic lost, int st);
        rev_t r;
        r.period = p;  r.acp_n = a;    r.trig_n = t;    r.arp_hi = h;
        r.exp_us = us; r.exp_acp = ac; r.exp_trig = tr;
        r.exp_cal = cal; r.exp_lost = lost; r.exp_state = st;
        return r;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, " arp_us"}, arp_us, 0);
        check({tag, " acp_cnt"}, acp_cnt, 0);
        check({tag, " trig_cnt"}, trig_cnt, 0);
        check({tag, " calibrated"}, calibrated, 0);
        check({tag, " stat_valid"}, stat_valid, 0);
        check({tag, " arp_lost"}, arp_lost, 0);
        check({tag, " state"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        // Section A: lock, jitter, ACP drift, held-high ARP.
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 0 first published
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 1
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 2
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 1, 0, ST_LOCKED));  // 3 fifth ARP rise
        tbl.push_back(mk(2002, 200, 1000, 1, 2002, 200, 1000, 1, 0, ST_LOCKED));  // 4 jitter +2 ok
        tbl.push_back(mk(2000, 200,  999, 1, 2000, 200,  999, 1, 0, ST_LOCKED));  // 5 TRIG ignored
        tbl.push_back(mk(2003, 200, 1000, 1, 2003, 200, 1000, 0, 0, ST_CHECK));   // 6 jitter +3 drops
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 7 vs 2003: re-ref
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 8
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 9
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 1, 0, ST_LOCKED));  // 10 relock
        tbl.push_back(mk(2000, 199, 1000, 1, 2000, 199, 1000, 0, 0, ST_CHECK));   // 11 ACP drift
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 12 re-ref
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 13
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 14
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 1, 0, ST_LOCKED));  // 15
        tbl.push_back(mk(2000, 200, 1000, 50, 2000, 200, 1000, 1, 0, ST_LOCKED)); // 16 ARP held 50
        // Section B: recovery after timeout, then a mismatch into CHECK.
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 1, ST_CHECK));   // 17
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 1, ST_CHECK));   // 18
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 1, ST_CHECK));   // 19
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 1, 0, ST_LOCKED));  // 20 lost clears
        tbl.push_back(mk(2003, 200, 1000, 1, 2003, 200, 1000, 0, 0, ST_CHECK));   // 21
        // Section C: relock after mid-CHECK reset.
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 22
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 23
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 0, 0, ST_CHECK));   // 24
        tbl.push_back(mk(2000, 200, 1000, 1, 2000, 200, 1000, 1, 0, ST_LOCKED));  // 25

        // Clock/reset.
        rst = 1'b1;
        repeat (3) apply(1'b0, 1'b0, 1'b0);
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (5) apply(1'b0, 1'b0, 1'b0);

        // First ARP rise only starts measuring.
        arp_edge();
        check("first_edge stat_valid", stat_valid, 0);
        check("first_edge arp_us", arp_us, 0);
        check("first_edge state", dbg_state, ST_MEASURE);

        for (int i = 0; i <= 16; i++) run_rev(i, tbl[i]);

        // Timeout: last ARP rise was the edge closing record 16.
        repeat (4999) apply(1'b0, 1'b0, 1'b0);
        check("pre_timeout calibrated", calibrated, 1);
        check("pre_timeout arp_lost", arp_lost, 0);
        apply(1'b0, 1'b0, 1'b0);
        check("timeout calibrated", calibrated, 0);
        check("timeout arp_lost", arp_lost, 1);
        check("timeout state", dbg_state, ST_IDLE);
        check("timeout arp_us_hold", arp_us, 2000);
        check("timeout stat_valid", stat_valid, 0);
        repeat (100) apply(1'b0, 1'b0, 1'b0);
        check("idle state", dbg_state, ST_IDLE);

        arp_edge();
        check("resume stat_valid", stat_valid, 0);
        check("resume state", dbg_state, ST_MEASURE);
        check("resume arp_lost", arp_lost, 1);

        for (int i = 17; i <= 21; i++) run_rev(i, tbl[i]);

        // Reset partway through a CHECK revolution.
        begin
            int vc;
            body(501, 200, 1000, 1, vc);
            check("pre_reset state", dbg_state, ST_CHECK);
        end
        rst = 1'b1;
        apply(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check_zero_outputs("midcheck_reset");
        repeat (100) apply(1'b0, 1'b0, 1'b0);
        arp_edge();
        check("post_reset stat_valid", stat_valid, 0);
        check("post_reset arp_us", arp_us, 0);
        check("post_reset state", dbg_state, ST_MEASURE);

        for (int i = 22; i <= 25; i++) run_rev(i, tbl[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
